// File: rtl/task_batcher.sv
// Task batcher: collects single-slot task requests into an 8-bit batch vector
// and hands the frozen batch to a downstream load balancer over a valid/ready pair.
module task_batcher #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_id,
    output logic       req_ready,
    input  logic       flush,
    output logic [7:0] tasks,
    output logic       batch_valid,
    input  logic       batch_ready,
    output logic [3:0] pending,
    output logic       dup_err,
    output logic [1:0] state_dbg
);

    // Handshakes: a request is taken on any rising edge where req_valid && req_ready;
    // a batch is handed off on any rising edge where batch_valid && batch_ready.
    // tasks is held frozen from the rise of batch_valid until that hand-off edge.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] vec_q;
    logic [7:0] vec_d;
    logic [7:0] timer_q;
    logic [7:0] timer_d;
    logic [7:0] slot_mask;
    logic       accept;
    logic       slot_hit;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    assign req_ready = (state_q != ISSUE);
    assign state_dbg = state_q;
    assign accept    = req_valid && req_ready;
    assign slot_mask = 8'd1 << req_id;
    assign slot_hit  = accept && ((vec_q & slot_mask) != 8'd0);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    vec_d   = slot_mask;
                    timer_d = TIMER_LOAD;
                    state_d = flush ? ISSUE : COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    vec_d = vec_q | slot_mask;
                end
                if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end
                // A request arriving on the closing edge still rides in this batch.
                if ((vec_d == 8'hFF) || (timer_q == 8'd0) || flush) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (batch_ready) begin
                    vec_d   = 8'd0;
                    timer_d = 8'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                vec_d   = 8'd0;
                timer_d = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            vec_q       <= 8'd0;
            timer_q     <= 8'd0;
            tasks       <= 8'd0;
            batch_valid <= 1'b0;
            pending     <= 4'd0;
            dup_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            timer_q     <= timer_d;
            batch_valid <= (state_d == ISSUE);
            tasks       <= (state_d == ISSUE) ? vec_d : 8'd0;
            pending     <= popcount8(vec_d);
            dup_err     <= slot_hit;
        end
    end

endmodule

// File: tb/tb_task_batcher.sv
// Directed bench for task_batcher: three instances (TIMEOUT 8, 4, 1) share the
// request/flush/ready inputs; each scenario resets them all and checks one.
module tb_task_batcher;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_id;
    logic       flush;
    logic       batch_ready;

    logic       req_ready_w   [3];
    logic [7:0] tasks_w       [3];
    logic       batch_valid_w [3];
    logic [3:0] pending_w     [3];
    logic       dup_err_w     [3];
    logic [1:0] state_dbg_w   [3];

    int n_checks;
    int n_fail;
    logic [7:0] exp_q[$];

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;
    localparam int D8 = 0;
    localparam int D4 = 1;
    localparam int D1 = 2;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        task_batcher #(
            .TIMEOUT((g == 0) ? 8 : (g == 1) ? 4 : 1)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid),
            .req_id     (req_id),
            .req_ready  (req_ready_w[g]),
            .flush      (flush),
            .tasks      (tasks_w[g]),
            .batch_valid(batch_valid_w[g]),
            .batch_ready(batch_ready),
            .pending    (pending_w[g]),
            .dup_err    (dup_err_w[g]),
            .state_dbg  (state_dbg_w[g])
        );
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_id      = 3'd0;
        flush       = 1'b0;
        batch_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic send(input logic [2:0] id);
        req_valid = 1'b1;
        req_id    = id;
        step();
        req_valid = 1'b0;
    endtask

    // scoreboard: compare the held batch against the oldest expectation, then hand it off
    task automatic drain(input int d, input string tag);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 32'd1, 32'd0);
            return;
        end
        exp = exp_q.pop_front();
        check({tag, "_bv"}, 32'(batch_valid_w[d]), 32'd1);
        check({tag, "_tasks"}, 32'(tasks_w[d]), 32'(exp));
        batch_ready = 1'b1;
        step();
        batch_ready = 1'b0;
        check({tag, "_bv_done"}, 32'(batch_valid_w[d]), 32'd0);
        check({tag, "_tasks_done"}, 32'(tasks_w[d]), 32'd0);
        check({tag, "_pend_done"}, 32'(pending_w[d]), 32'd0);
        check({tag, "_st_done"}, 32'(state_dbg_w[d]), 32'(S_IDLE));
        check({tag, "_rdy_done"}, 32'(req_ready_w[d]), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        reset = 1'b0;
        #12;
        for (int d = 0; d < 3; d++) begin
            check("rst_tasks", 32'(tasks_w[d]), 32'd0);
            check("rst_bv", 32'(batch_valid_w[d]), 32'd0);
            check("rst_pend", 32'(pending_w[d]), 32'd0);
            check("rst_dup", 32'(dup_err_w[d]), 32'd0);
        end
        reset = 1'b1;
        step();
        check("rst_rdy", 32'(req_ready_w[D8]), 32'd1);
        check("rst_st", 32'(state_dbg_w[D8]), 32'(S_IDLE));

        // ids 0..7 fill the vector before the 8-cycle timer expires
        do_reset();
        for (int i = 0; i < 7; i++) send(3'(i));
        check("fill_bv_early", 32'(batch_valid_w[D8]), 32'd0);
        check("fill_pend7", 32'(pending_w[D8]), 32'd7);
        check("fill_st", 32'(state_dbg_w[D8]), 32'(S_COLLECT));
        send(3'd7);
        exp_q.push_back(8'hFF);
        check("fill_pend8", 32'(pending_w[D8]), 32'd8);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fill_hold_bv", 32'(batch_valid_w[D8]), 32'd1);
            check("fill_hold_tasks", 32'(tasks_w[D8]), 32'hFF);
            check("fill_hold_rdy", 32'(req_ready_w[D8]), 32'd0);
        end
        drain(D8, "fill");

        // ids 2 and 5, TIMEOUT=4: batch appears on the 4th edge after the first accept
        do_reset();
        send(3'd2);
        send(3'd5);
        step();
        step();
        check("to4_bv_e3", 32'(batch_valid_w[D4]), 32'd0);
        step();
        exp_q.push_back(8'h24);
        check("to4_pend", 32'(pending_w[D4]), 32'd2);
        drain(D4, "to4");

        // duplicate id 3
        do_reset();
        send(3'd3);
        check("dup_first", 32'(dup_err_w[D8]), 32'd0);
        send(3'd3);
        check("dup_pulse", 32'(dup_err_w[D8]), 32'd1);
        send(3'd6);
        check("dup_clear", 32'(dup_err_w[D8]), 32'd0);
        check("dup_pend", 32'(pending_w[D8]), 32'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.push_back(8'h48);
        check("dup_pend_issue", 32'(pending_w[D8]), 32'd2);
        check("dup_no_pulse", 32'(dup_err_w[D8]), 32'd0);
        drain(D8, "dup");

        // flush after id 1, downstream stalls; requests offered while stalled are refused
        do_reset();
        send(3'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.push_back(8'h02);
        req_valid = 1'b1;
        req_id    = 3'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_tasks", 32'(tasks_w[D8]), 32'h02);
            check("stall_rdy", 32'(req_ready_w[D8]), 32'd0);
            check("stall_pend", 32'(pending_w[D8]), 32'd1);
        end
        req_valid = 1'b0;
        drain(D8, "stall");

        // reset mid-collect discards the partial batch
        do_reset();
        send(3'd0);
        send(3'd1);
        send(3'd2);
        check("mid_pend3", 32'(pending_w[D8]), 32'd3);
        reset = 1'b0;
        #1;
        check("mid_rst_pend", 32'(pending_w[D8]), 32'd0);
        check("mid_rst_bv", 32'(batch_valid_w[D8]), 32'd0);
        check("mid_rst_tasks", 32'(tasks_w[D8]), 32'd0);
        check("mid_rst_dup", 32'(dup_err_w[D8]), 32'd0);
        step();
        reset = 1'b1;
        step();
        check("mid_after_bv", 32'(batch_valid_w[D8]), 32'd0);
        send(3'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.push_back(8'h80);
        drain(D8, "mid");

        // id 4 accepted on the edge where the timer reaches 0
        do_reset();
        send(3'd0);
        step();
        step();
        step();
        check("edge_bv_pre", 32'(batch_valid_w[D4]), 32'd0);
        send(3'd4);
        exp_q.push_back(8'h11);
        drain(D4, "edge");

        // TIMEOUT=1: issue on the edge after the first accept
        do_reset();
        send(3'd6);
        check("to1_bv_e0", 32'(batch_valid_w[D1]), 32'd0);
        step();
        exp_q.push_back(8'h40);
        drain(D1, "to1");

        // flush in IDLE: ignored alone, immediate issue with an accept
        do_reset();
        flush = 1'b1;
        step();
        check("iflush_st", 32'(state_dbg_w[D8]), 32'(S_IDLE));
        check("iflush_bv", 32'(batch_valid_w[D8]), 32'd0);
        send(3'd3);
        flush = 1'b0;
        check("iflush_st_iss", 32'(state_dbg_w[D8]), 32'(S_ISSUE));
        exp_q.push_back(8'h08);
        drain(D8, "iflush");

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/task_batcher.md
TASK_BATCHER -- requirements
Module: task_batcher

Interface
REQ-001 Parameter: TIMEOUT, 8, cycles from first accepted request to forced batch issue; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  1  upstream task request present.
REQ-005 Port: req_id  input  3  task slot index (0..7) of the request.
REQ-006 Port: req_ready  output  1  batcher can accept a request this cycle.
REQ-007 Port: flush  input  1  issue the current partial batch early.
REQ-008 Port: tasks  output  8  batch vector; bit i set = task slot i requested.
REQ-009 Port: batch_valid  output  1  tasks holds a complete batch for the downstream load balancer.
REQ-010 Port: batch_ready  input  1  downstream accepts the batch this cycle.
REQ-011 Port: pending  output  4  number of set bits in the collecting vector (0..8).
REQ-012 Port: dup_err  output  1  one-cycle pulse: accepted request hit an already-set slot.

Function
REQ-013 The FSM SHALL have three states: IDLE, COLLECT, ISSUE.
REQ-014 Request accept SHALL occur when req_valid and req_ready are both 1 at a clock edge.
REQ-015 req_ready SHALL be 1 in IDLE and COLLECT and 0 in ISSUE.
REQ-016 IDLE: on accept, set bit req_id, load timer with TIMEOUT-1, go to COLLECT; otherwise stay in IDLE.
REQ-017 COLLECT: each accept SHALL set bit req_id; the timer SHALL decrement by 1 per cycle and SHALL NOT reload on later accepts.
REQ-018 An accept whose slot bit is already set SHALL leave the vector unchanged and SHALL pulse dup_err high for exactly the following cycle.
REQ-019 COLLECT SHALL go to ISSUE at the edge where any of these holds: the vector becomes 8'hFF, timer equals 0, or flush is 1.
REQ-020 A request accepted on the same edge as the COLLECT->ISSUE transition SHALL be included in the issued batch.
REQ-021 flush in IDLE with no accept SHALL be ignored; flush in IDLE with an accept SHALL go directly to ISSUE with that single bit.
REQ-022 With TIMEOUT=1, the first accept SHALL lead to ISSUE on the next edge.
REQ-023 ISSUE: batch_valid SHALL be 1, and tasks SHALL hold the frozen vector, stable until batch_ready is sampled 1.
REQ-024 ISSUE with batch_ready=1: clear the vector and timer and go to IDLE; the earliest new accept is on the following cycle.
REQ-025 tasks SHALL read 8'h00 whenever batch_valid is 0.
REQ-026 pending SHALL be the registered population count of the vector; it SHALL hold in ISSUE and be 0 in IDLE.
REQ-027 batch_valid SHALL never assert with an all-zero vector.
REQ-028 All outputs SHALL be registered, except req_ready, which SHALL be decoded from state.

Reset
REQ-029 reset low SHALL asynchronously force IDLE, vector=0, timer=0, tasks=0, batch_valid=0, pending=0, dup_err=0, and req_ready=1 on the first edge after release.
REQ-030 reset asserted mid-COLLECT or mid-ISSUE SHALL discard the batch with no batch_valid pulse.

Verification
REQ-031 Requests with ids 0..7, one per cycle, TIMEOUT=8 -> ISSUE after the 8th accept, tasks=8'hFF, batch_valid held until batch_ready.
REQ-032 Requests with ids 2 and 5, then idle, TIMEOUT=4 -> batch_valid rises 4 cycles after the first accept, tasks=8'h24, pending=2.
REQ-033 Requests with ids 3, 3, 6 -> dup_err pulses once after the 2nd accept; batch tasks=8'h48; pending=2.
REQ-034 Request with id 1, flush next cycle -> ISSUE with tasks=8'h02; with batch_ready held 0 for 5 cycles, tasks stays stable and req_ready=0.
REQ-035 reset low during COLLECT with pending=3 -> all outputs 0 immediately; after release, a request with id 7 yields tasks=8'h80 only.
REQ-036 Request with id 4 on the edge the timer hits 0, vector holding id 0 -> issued tasks=8'h11.
